// File: rtl/axi_arb_pkg.sv
// Shared defaults, FSM state encoding and request-source encoding for the
// single-slave AXI arbiter.
package axi_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ID_W_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_XFER = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  // S0 = m0 read, S1 = m1 read, S2 = m1 write
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } src_e;

  // Round-robin successor: S0 -> S1 -> S2 -> S0
  function automatic src_e src_step(input src_e s);
    case (s)
      S0:      src_step = S1;
      S1:      src_step = S2;
      default: src_step = S0;
    endcase
  endfunction

endpackage

// File: rtl/axi_arbiter_rr_arbiter3.sv
// Three-request round-robin picker. The pointer names the source that is
// considered first; it moves to the successor of the winner when the grant
// is taken.
module rr_arbiter3
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output src_e       gnt_src
);

  src_e ptr_q, ptr_d;
  src_e cand;

  // Scan the three sources starting at the pointer; first requester wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = ptr_q;
    cand      = ptr_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_src   = cand;
      end
      cand = src_step(cand);
    end
    ptr_d = (advance && gnt_valid) ? src_step(gnt_src) : ptr_q;
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= S0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_arbiter.sv
// Two-master to one-slave AXI arbiter with a single outstanding transaction.
// m0 is read-only (instruction fetch); m1 has read and write channels.
module axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ID_W   = ID_W_DEF
) (
  input  logic                aclk,
  input  logic                aresetn,
  // m0 read address / data
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [ID_W-1:0]     m0_rid,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  // m1 read address / data
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ID_W-1:0]     m1_rid,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  // m1 write address / data / response
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [ID_W-1:0]     m1_bid,
  output logic [1:0]          m1_bresp,
  // slave port
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [ID_W-1:0]     s_rid,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [ID_W-1:0]     s_bid,
  input  logic [1:0]          s_bresp,
  output logic                err
);

  state_e     state_q, state_d;
  src_e       owner_q, owner_d;
  logic [7:0] arlen_q, arlen_d;
  logic [7:0] beat_q, beat_d;
  logic       aw_done_q, aw_done_d;
  logic       wl_done_q, wl_done_d;
  logic       err_q, err_d;

  logic       gnt_valid;
  src_e       gnt_src;
  logic       grant_take;
  logic       aw_hs;
  logic       wl_hs;

  rr_arbiter3 u_rr (
    .clk       (aclk),
    .rst_n     (aresetn),
    .req       ({m1_awvalid, m1_arvalid, m0_arvalid}),
    .advance   (grant_take),
    .gnt_valid (gnt_valid),
    .gnt_src   (gnt_src)
  );

  assign err = err_q;

  // Next-state logic and channel routing; everything defaults to idle/zero
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    arlen_d    = arlen_q;
    beat_d     = beat_q;
    aw_done_d  = aw_done_q;
    wl_done_d  = wl_done_q;
    err_d      = err_q;
    grant_take = 1'b0;
    aw_hs      = 1'b0;
    wl_hs      = 1'b0;

    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rid     = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rid     = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bid     = '0;
    m1_bresp   = '0;

    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_take = 1'b1;
          owner_d    = gnt_src;
          aw_done_d  = 1'b0;
          wl_done_d  = 1'b0;
          state_d    = (gnt_src == S2) ? WR_XFER : RD_ADDR;
        end
      end

      RD_ADDR: begin
        if (owner_q == S0) begin
          s_arvalid  = m0_arvalid;
          s_araddr   = m0_araddr;
          s_arid     = m0_arid;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          m0_arready = s_arready;
        end else begin
          s_arvalid  = m1_arvalid;
          s_araddr   = m1_araddr;
          s_arid     = m1_arid;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          m1_arready = s_arready;
        end
        if (s_arvalid && s_arready) begin
          arlen_d = s_arlen;
          beat_d  = '0;
          state_d = RD_DATA;
        end
      end

      RD_DATA: begin
        if (owner_q == S0) begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rid    = s_rid;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          s_rready  = m0_rready;
        end else begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rid    = s_rid;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          s_rready  = m1_rready;
        end
        if (s_rvalid && s_rready) begin
          beat_d = beat_q + 8'd1;
          // rlast must coincide exactly with the final beat of the latched length
          if (s_rlast != (beat_q == arlen_q)) begin
            err_d = 1'b1;
          end
          if (s_rlast) begin
            state_d = IDLE;
          end
        end
      end

      WR_XFER: begin
        // AW and W run independently; each side is masked once it has completed
        s_awvalid  = m1_awvalid & ~aw_done_q;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready & ~aw_done_q;
        s_wvalid   = m1_wvalid & ~wl_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready & ~wl_done_q;
        aw_hs      = s_awvalid && s_awready;
        wl_hs      = s_wvalid && s_wready && m1_wlast;
        if (aw_hs) begin
          aw_done_d = 1'b1;
        end
        if (wl_hs) begin
          wl_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (wl_done_q || wl_hs)) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        m1_bvalid = s_bvalid;
        m1_bid    = s_bid;
        m1_bresp  = s_bresp;
        s_bready  = m1_bready;
        if (s_bvalid && s_bready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction state registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      owner_q   <= S0;
      arlen_q   <= '0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      wl_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arlen_q   <= arlen_d;
      beat_q    <= beat_d;
      aw_done_q <= aw_done_d;
      wl_done_q <= wl_done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: the bench plays both masters and the slave.
module tb_axi_arbiter;

  logic        aclk;
  logic        aresetn;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_araddr;
  logic [3:0]  m0_arid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst;
  logic        m0_rvalid, m0_rready;
  logic [63:0] m0_rdata;
  logic [3:0]  m0_rid;
  logic [1:0]  m0_rresp;
  logic        m0_rlast;
  logic        m1_arvalid, m1_arready;
  logic [31:0] m1_araddr;
  logic [3:0]  m1_arid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst;
  logic        m1_rvalid, m1_rready;
  logic [63:0] m1_rdata;
  logic [3:0]  m1_rid;
  logic [1:0]  m1_rresp;
  logic        m1_rlast;
  logic        m1_awvalid, m1_awready;
  logic [31:0] m1_awaddr;
  logic [3:0]  m1_awid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst;
  logic        m1_wvalid, m1_wready;
  logic [63:0] m1_wdata;
  logic [7:0]  m1_wstrb;
  logic        m1_wlast;
  logic        m1_bvalid, m1_bready;
  logic [3:0]  m1_bid;
  logic [1:0]  m1_bresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [3:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        err;

  int tests_run;
  int tests_failed;
  int whs;

  axi_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rid(m0_rid), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rid(m1_rid), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_awid(m1_awid), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; whs = 0;
    aresetn = 1'b0;
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
    m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
    m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = '0; m1_awburst = '0;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = '0; s_bresp = '0;

    // ---- reset state
    tick(); tick();
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_s_awvalid", 64'(s_awvalid), 64'd0);
    chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("rst_m1_bvalid", 64'(m1_bvalid), 64'd0);
    chk("rst_err",       64'(err),       64'd0);
    aresetn = 1'b1;
    tick();

    // ---- single-beat m0 read
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arid = 4'h3; m0_arlen = 8'd0;
    m0_arsize = 3'd3; m0_arburst = 2'd1;
    #1 chk("idle_no_s_arvalid", 64'(s_arvalid), 64'd0);
    tick();
    chk("r0_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("r0_s_araddr",  64'(s_araddr),  64'h8000_0000);
    chk("r0_s_arid",    64'(s_arid),    64'h3);
    s_arready = 1;
    #1 chk("r0_m0_arready", 64'(m0_arready), 64'd1);
    chk("r0_m1_arready", 64'(m1_arready), 64'd0);
    tick();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'h1122_3344_5566_7788; s_rid = 4'h3; s_rresp = 2'd0; s_rlast = 1;
    m0_rready = 1;
    #1 chk("r0_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("r0_m0_rdata", m0_rdata, 64'h1122_3344_5566_7788);
    chk("r0_m0_rlast", 64'(m0_rlast), 64'd1);
    chk("r0_m0_rid",   64'(m0_rid),   64'h3);
    chk("r0_m1_rvalid", 64'(m1_rvalid), 64'd0);
    chk("r0_s_rready",  64'(s_rready),  64'd1);
    tick();
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    #1 chk("r0_done_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("r0_done_err", 64'(err), 64'd0);

    // ---- simultaneous S0/S1/S2 right after reset: S0, then S1, then S2
    aresetn = 0; tick(); aresetn = 1;
    m0_arvalid = 1; m0_araddr = 32'h8000_0100; m0_arid = 4'h1; m0_arlen = 8'd0;
    m1_arvalid = 1; m1_araddr = 32'h8000_0200; m1_arid = 4'h2; m1_arlen = 8'd0;
    m1_awvalid = 1; m1_awaddr = 32'h8000_1000; m1_awid = 4'h5; m1_awlen = 8'd3;
    m1_awsize = 3'd3; m1_awburst = 2'd1;
    #1 chk("rr_idle_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rr_idle_s_awvalid", 64'(s_awvalid), 64'd0);
    tick();
    chk("rr1_s_araddr",  64'(s_araddr),  64'h8000_0100);
    chk("rr1_s_awvalid", 64'(s_awvalid), 64'd0);
    s_arready = 1;
    #1 chk("rr1_m0_arready", 64'(m0_arready), 64'd1);
    chk("rr1_m1_arready", 64'(m1_arready), 64'd0);
    chk("rr1_m1_awready", 64'(m1_awready), 64'd0);
    tick();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'hA5; s_rid = 4'h1; s_rlast = 1; m0_rready = 1;
    #1 chk("rr1_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("rr1_m1_rvalid", 64'(m1_rvalid), 64'd0);
    tick();
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    #1 chk("rr_idle2_s_arvalid", 64'(s_arvalid), 64'd0);
    tick();
    chk("rr2_s_araddr",  64'(s_araddr),  64'h8000_0200);
    chk("rr2_s_arid",    64'(s_arid),    64'h2);
    chk("rr2_s_awvalid", 64'(s_awvalid), 64'd0);
    s_arready = 1;
    #1 chk("rr2_m1_arready", 64'(m1_arready), 64'd1);
    chk("rr2_m0_arready", 64'(m0_arready), 64'd0);
    tick();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'hBEEF; s_rid = 4'h2; s_rlast = 1; m1_rready = 1;
    #1 chk("rr2_m1_rvalid", 64'(m1_rvalid), 64'd1);
    chk("rr2_m1_rid",    64'(m1_rid),    64'h2);
    chk("rr2_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("rr2_s_awvalid_busy", 64'(s_awvalid), 64'd0);
    tick();
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    tick();

    // ---- m1 write, awlen=3, four beats
    chk("w_s_awvalid", 64'(s_awvalid), 64'd1);
    chk("w_s_awaddr",  64'(s_awaddr),  64'h8000_1000);
    chk("w_s_awlen",   64'(s_awlen),   64'd3);
    chk("w_s_awid",    64'(s_awid),    64'h5);
    s_awready = 1; s_wready = 1;
    m1_wvalid = 1; m1_wstrb = 8'hFF;
    for (int b = 0; b < 4; b++) begin
      m1_wdata = 64'h1000 + 64'(b);
      m1_wlast = (b == 3);
      #1;
      if (b == 0) begin
        chk("w_m1_awready", 64'(m1_awready), 64'd1);
        chk("w_s_wstrb",    64'(s_wstrb),    64'hFF);
      end
      if (b == 3) chk("w_s_wlast", 64'(s_wlast), 64'd1);
      if (s_wvalid && s_wready) whs++;
      tick();
      if (b == 0) begin
        chk("w_aw_masked_after_hs", 64'(s_awvalid), 64'd0);
        m1_awvalid = 0; s_awready = 0;
      end
    end
    m1_wvalid = 0; m1_wlast = 0;
    #1 chk("w_handshakes", 64'(whs), 64'd4);
    chk("w_resp_s_wvalid", 64'(s_wvalid), 64'd0);
    s_wready = 1;
    #1 chk("w_resp_m1_wready", 64'(m1_wready), 64'd0);
    s_bvalid = 1; s_bid = 4'h5; s_bresp = 2'd0; m1_bready = 1;
    #1 chk("w_m1_bvalid", 64'(m1_bvalid), 64'd1);
    chk("w_m1_bresp",  64'(m1_bresp),  64'd0);
    chk("w_m1_bid",    64'(m1_bid),    64'h5);
    chk("w_s_bready",  64'(s_bready),  64'd1);
    tick();
    s_bvalid = 0; m1_bready = 0; s_wready = 0;
    #1 chk("w_done_m1_bvalid", 64'(m1_bvalid), 64'd0);

    // ---- early rlast on beat 2 of arlen=3 -> sticky err
    m1_arvalid = 1; m1_araddr = 32'h8000_2000; m1_arid = 4'h6; m1_arlen = 8'd3;
    tick();
    s_arready = 1;
    tick();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rid = 4'h6; m1_rready = 1;
    for (int b = 0; b < 3; b++) begin
      s_rdata = 64'(b);
      s_rlast = (b == 2);
      #1;
      if (b == 2) chk("e_err_before_bad_beat", 64'(err), 64'd0);
      tick();
    end
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    #1 chk("e_err_set", 64'(err), 64'd1);
    tick(); tick();
    chk("e_err_sticky", 64'(err), 64'd1);
    chk("e_m1_rvalid_idle", 64'(m1_rvalid), 64'd0);

    // ---- reset during beat 1 of a 4-beat m0 read, then a normal m1 read
    aresetn = 0; tick(); aresetn = 1;
    chk("a_err_cleared", 64'(err), 64'd0);
    m0_arvalid = 1; m0_araddr = 32'h8000_3000; m0_arid = 4'h7; m0_arlen = 8'd3;
    tick();
    s_arready = 1;
    tick();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rid = 4'h7; s_rdata = 64'hC0; s_rlast = 0; m0_rready = 1;
    tick();
    s_rdata = 64'hC1;
    #1 chk("a_beat1_m0_rvalid", 64'(m0_rvalid), 64'd1);
    aresetn = 0;
    #1 chk("a_rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("a_rst_s_rready",  64'(s_rready),  64'd0);
    chk("a_rst_m0_rdata",  m0_rdata,       64'd0);
    chk("a_rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("a_rst_s_awvalid", 64'(s_awvalid), 64'd0);
    tick();
    s_rvalid = 0; m0_rready = 0; s_rdata = '0;
    aresetn = 1;
    m1_arvalid = 1; m1_araddr = 32'h8000_4000; m1_arid = 4'h9; m1_arlen = 8'd0;
    tick();
    chk("a_m1_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("a_m1_s_araddr",  64'(s_araddr),  64'h8000_4000);
    s_arready = 1;
    tick();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 64'hCAFE; s_rid = 4'h9; s_rlast = 1; m1_rready = 1;
    #1 chk("a_m1_rvalid", 64'(m1_rvalid), 64'd1);
    chk("a_m1_rdata",  m1_rdata,        64'hCAFE);
    chk("a_m1_rlast",  64'(m1_rlast),   64'd1);
    chk("a_m0_rvalid", 64'(m0_rvalid),  64'd0);
    tick();
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    #1 chk("a_done_err", 64'(err), 64'd0);
    chk("a_done_m1_rvalid", 64'(m1_rvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 The module SHALL have parameter DATA_W, default 64, R/W data width; strobe width is DATA_W/8.
REQ-003 The module SHALL have parameter ID_W, default 4, AXI ID width.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 m0_ar{valid,addr,id,len[7:0],size[2:0],burst[1:0]} in / m0_arready out  instruction-fetch read-address channel.
REQ-007 m0_r{valid,data,id,resp[1:0],last} out / m0_rready in  instruction-fetch read-data channel.
REQ-008 m1_ar*/m1_r*  same shape as REQ-006/007  load-store read channels.
REQ-009 m1_aw{valid,addr,id,len,size,burst} in / m1_awready out  load-store write-address channel.
REQ-010 m1_w{valid,data,strb,last} in / m1_wready out  load-store write-data channel.
REQ-011 m1_b{valid,id,resp[1:0]} out / m1_bready in  load-store write-response channel.
REQ-012 s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored directions  single slave port to the simulated SRAM.
REQ-013 err  out  1  sticky protocol error flag.

Function
REQ-014 Exactly one transaction SHALL be outstanding on the slave port at any time.
REQ-015 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP.
REQ-016 Request sources: S0 = m0_arvalid, S1 = m1_arvalid, S2 = m1_awvalid; IDLE SHALL grant round-robin in order S0->S1->S2, starting after the last granted source.
REQ-017 The grant SHALL be registered: a request sampled in IDLE reaches the slave valid one cycle later (RD_ADDR or WR_XFER).
REQ-018 RD_ADDR SHALL forward the owner's AR signals to s_ar* and s_arready to the owner's arready; on handshake it SHALL latch arlen, clear the beat counter and enter RD_DATA.
REQ-019 RD_DATA SHALL route s_r* to the owner, s_rready from the owner, increment the beat counter per handshake, and return to IDLE on a handshake with s_rlast=1.
REQ-020 A handshake with rlast=1 at count != latched arlen, or rlast=0 at count == arlen, SHALL set err.
REQ-021 WR_XFER SHALL forward AW and W concurrently; after AW handshake s_awvalid SHALL be 0; it exits to WR_RESP on a W handshake with wlast=1 once AW is done.
REQ-022 WR_RESP SHALL route s_b* to m1_b*; it returns to IDLE on B handshake.
REQ-023 Non-owner masters SHALL see arready/awready/wready/rvalid/bvalid = 0; slave valids SHALL be 0 in IDLE.
REQ-024 IDs SHALL pass through unmodified; response routing uses the registered owner only.
REQ-025 Simultaneous S0/S1/S2 in IDLE: exactly one grant per IDLE cycle; losers wait with valid held.
REQ-026 A write is never granted while a read is in flight, and vice versa.

Reset
REQ-027 On aresetn low: state=IDLE, round-robin pointer=S0 next, beat counter=0, err=0, all valid/ready outputs 0, data/id/resp outputs 0.
REQ-028 Reset mid-burst SHALL abort immediately with no further slave handshakes; no state is retained.

Structure
REQ-029 Package axi_arb_pkg SHALL hold ADDR_W/DATA_W/ID_W defaults, the FSM state enum and the source enum {S0,S1,S2}.
REQ-030 A sub-module rr_arbiter3 (3-request round-robin picker with pointer register) SHALL provide the IDLE grant.
REQ-031 Muxes and the FSM SHALL remain in axi_arbiter.

Verification
REQ-032 m0 read arlen=0 addr 0x80000000, slave data 0x1122334455667788 -> m0_rdata matches, m0_rlast=1, m1 sees no rvalid.
REQ-033 m0 and m1 arvalid same cycle after reset -> m0 granted first, m1 granted on next IDLE, then S2 next if pending.
REQ-034 m1 write awlen=3 addr 0x80001000, 4 beats strb 0xFF -> 4 slave W handshakes, then m1_bvalid with bresp=0.
REQ-035 Slave asserts rlast on beat 2 of arlen=3 burst -> err=1 and stays 1 until reset.
REQ-036 aresetn pulsed low during beat 1 of a 4-beat read -> all valids 0 within the reset cycle, state IDLE, next m1 read completes normally.
